// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI3 read-address / read-data channel pair between the
// instruction-fetch port and the data-load port. Only one single-beat read is
// in flight at a time. The AR fields are latched at grant time and the R beat
// is routed back to whichever requester owns the transaction.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace the fixed
// data-over-inst priority with alternating priority. Under contention, the
// requester that did not win last time is granted.
//
// Handshake semantics: a transfer on AR happens on a rising edge where
// arvalid && arready are both high. A transfer on R happens on a rising edge
// where rvalid && rready are both high. Once arvalid is asserted, it stays
// high with araddr/arid/arsize stable until that handshake. On the requester
// side, *_req is held until the matching *_gnt is seen high in the same
// cycle. *_rvalid is a single-cycle pulse with *_rdata valid alongside it.
module axi_read_arbiter #(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter logic [3:0]  INST_ID = 4'd0,
   parameter logic [3:0]  DATA_ID = 4'd1
) (
   input  logic              aclk,
   input  logic              aresetn,
   // instruction-fetch requester
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_rvalid,
   // data-load requester
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [2:0]        data_size,
   output logic              data_gnt,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_rvalid,
   // status
   output logic              rd_err,
   output logic              id_err,
   output logic              busy,
   // AXI3 read-address channel
   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   // AXI3 read-data channel
   input  logic [3:0]        rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t state;
   state_t state_n;

   // High when the current transaction belongs to the data-load port.
   logic owner_data;

   // Arbitration result for this cycle, meaningful only in IDLE.
   logic pick_data;

   // R beat classification while waiting for data.
   logic beat_ok;
   logic beat_bad;

`ifdef ARB_ROUND_ROBIN_EN
   // Owner of the most recent grant: 1 = data port, 0 = inst port.
   logic last_owner_data;

   // Alternate under contention; a lone requester always wins.
   always_comb begin
      pick_data = data_req && (!inst_req || !last_owner_data);
   end
`else
   // Fixed priority: the data port always beats the inst port.
   always_comb begin
      pick_data = data_req;
   end
`endif

   // Classify an incoming R beat against the latched transaction id.
   always_comb begin
      beat_ok  = (state == S_DATA) && rvalid && (rid == arid);
      beat_bad = (state == S_DATA) && rvalid && (rid != arid);
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and the combinational grants.
   always_comb begin
      state_n  = state;
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      case (state)
         S_IDLE: begin
            if (aresetn) begin
               if (pick_data) begin
                  data_gnt = 1'b1;
                  state_n  = S_ADDR;
               end else if (inst_req) begin
                  inst_gnt = 1'b1;
                  state_n  = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (arready) begin
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            // A matching beat without rlast is delivered, but the FSM keeps
            // waiting for the beat that closes the transaction.
            if (beat_ok && rlast) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Channel-level outputs are decoded directly from the state.
   always_comb begin
      arvalid = (state == S_ADDR);
      rready  = (state == S_DATA);
      busy    = (state != S_IDLE);
      arlen   = 4'd0;
      arburst = 2'b01;
      arlock  = 2'b00;
      arcache = 4'd0;
      arprot  = 3'd0;
   end

   // Capture the winning request's address, id and size at grant time.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         araddr     <= '0;
         arid       <= 4'd0;
         arsize     <= 3'd0;
         owner_data <= 1'b0;
      end else if (data_gnt) begin
         araddr     <= data_addr;
         arid       <= DATA_ID;
         arsize     <= data_size;
         owner_data <= 1'b1;
      end else if (inst_gnt) begin
         araddr     <= inst_addr;
         arid       <= INST_ID;
         arsize     <= 3'd2;
         owner_data <= 1'b0;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember who won the last grant to steer the next contention.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         last_owner_data <= 1'b0;
      end else if (data_gnt) begin
         last_owner_data <= 1'b1;
      end else if (inst_gnt) begin
         last_owner_data <= 1'b0;
      end
   end
`endif

   // Route an accepted R beat to its owner as a one-cycle pulse.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         inst_rvalid <= 1'b0;
         data_rvalid <= 1'b0;
         rd_err      <= 1'b0;
      end else begin
         inst_rvalid <= beat_ok && !owner_data;
         data_rvalid <= beat_ok && owner_data;
         rd_err      <= beat_ok && (rresp != 2'b00);
      end
   end

   // Requester data registers hold their last value between pulses.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         inst_rdata <= '0;
         data_rdata <= '0;
      end else if (beat_ok) begin
         if (owner_data) begin
            data_rdata <= rdata;
         end else begin
            inst_rdata <= rdata;
         end
      end
   end

   // A beat with a foreign id is dropped; the flag stays set until reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         id_err <= 1'b0;
      end else if (beat_bad) begin
         id_err <= 1'b1;
      end
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the core's single AXI3 read-address/read-data channel pair between two requesters: the instruction-fetch port and the data-load port.
- Sequences one single-beat read transaction at a time.
  - Drives the AR channel.
  - Accepts the R beat.
  - Routes the returned word and response status to the requester that owns the transaction.
- Sits between the pipeline's fetch/load request logic and the top-level AXI read pins.

Parameters:
- ADDR_W, 32, address width of requester ports and araddr.
- DATA_W, 32, data width of rdata and requester read data.
- INST_ID, 4'd0, arid used for instruction fetches.
- DATA_ID, 4'd1, arid used for data loads.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- inst_req  in  1  fetch request; held until granted.
- inst_addr  in  ADDR_W  fetch address; word-aligned.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rdata  out  DATA_W  fetched word; valid with inst_rvalid.
- inst_rvalid  out  1  one-cycle pulse; fetched word returned.
- data_req  in  1  load request; held until granted.
- data_addr  in  ADDR_W  load address.
- data_size  in  3  AXI size encoding: 0=byte, 1=half, 2=word.
- data_gnt  out  1  load request accepted this cycle.
- data_rdata  out  DATA_W  loaded word; valid with data_rvalid.
- data_rvalid  out  1  one-cycle pulse; load word returned.
- rd_err  out  1  pulse with inst_rvalid/data_rvalid when rresp != 2'b00.
- id_err  out  1  sticky; set when an R beat carries an unexpected rid.
- busy  out  1  high in any state other than IDLE.
- arid  out  4  INST_ID or DATA_ID of the current owner.
- araddr  out  ADDR_W  latched request address.
- arlen  out  4  constant 0 (single beat).
- arsize  out  3  2 for fetch; latched data_size for load.
- arburst  out  2  constant 2'b01 (INCR).
- arlock  out  2  constant 0.
- arcache  out  4  constant 0.
- arprot  out  3  constant 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  DATA_W  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset values (aresetn low at a rising edge): state=IDLE; arvalid=0, rready=0, inst_rvalid=0, data_rvalid=0, rd_err=0, id_err=0, busy=0; araddr/arid/arsize/rdata regs=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any request is present, select a winner. Fixed priority: data over inst.
  - Drive the winner's gnt combinationally high this cycle. Loser gnt stays 0.
  - Latch addr, id and size (inst → 3'd2). Go to ADDR.
  - No request → remain in IDLE.
- ADDR:
  - arvalid=1; araddr/arid/arsize held stable until handshake.
  - On arvalid&&arready → go to DATA and drop arvalid next cycle.
- DATA:
  - rready=1.
  - On rvalid with rid == latched id:
    - Register rdata into the owner's rdata output.
    - Pulse the owner's rvalid next cycle.
    - rd_err = (rresp != 0) in the same cycle as that rvalid pulse.
    - Go to IDLE if rlast=1.
  - rlast=0 on a matching beat: accept the beat, deliver it, stay in DATA (protocol tolerance).
  - rvalid with rid != latched id: beat consumed and discarded, id_err set (cleared only by reset), remain in DATA.
- Latency, zero-wait slave:
  - req at t0 → gnt at t0.
  - arvalid at t1 (arready at t1).
  - R beat at t2.
  - Owner rvalid at t3.
  - New grant possible at t3.
- Only one transaction is outstanding; no request is granted outside IDLE.
- Requester outputs (rdata) hold their last value between pulses. Requesters must not change addr while req is high and ungranted.
- Simultaneous inst_req and data_req in IDLE → data wins; inst is granted in the next IDLE cycle.
- A winner's req dropped in the grant cycle is irrelevant: the request is already latched.
- Reset mid-transaction (ADDR or DATA) → IDLE and all valids 0 next cycle. Any subsequent R beat arriving in IDLE is ignored (rready=0).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register (reset = inst) is updated at each grant.
  - When both requesters request in IDLE, the one that is not last_owner wins.
  - A single requester always wins.
- Undefined: fixed data-over-inst priority; no last_owner register.

Test Plan:
- Single fetch: inst_req, inst_addr=0xBFC00000, zero-wait slave returning rdata=0x3C1D0001, rid=0, rresp=0 → inst_gnt at t0; arvalid t1 with arid=0, arsize=2, arlen=0, arburst=1; inst_rvalid at t3 with inst_rdata=0x3C1D0001; rd_err=0.
- Contention: inst_req and data_req both high at t0, data_addr=0x80001004, data_size=0 → data_gnt at t0, arid=1, arsize=0; inst_gnt at the first IDLE after data_rvalid. With ARB_ROUND_ROBIN_EN: data wins the first, inst wins a second simultaneous contention.
- Back-pressure: arready held low 5 cycles → arvalid, araddr, arid stable all 5 cycles; single AR handshake; no second grant meanwhile.
- Error response: load with rresp=2'b10, rdata=0xDEADBEEF → data_rvalid and rd_err pulse together for 1 cycle; data_rdata=0xDEADBEEF; FSM back to IDLE.
- Bad id: in DATA for arid=0, slave sends rid=3 then rid=0 → first beat discarded, id_err=1 and stays set; inst_rvalid only for the second beat.
- Reset mid-op: aresetn low in DATA, then slave sends a late rvalid → busy=0, rready=0, no rvalid pulse, next request granted normally.
